// File: rtl/bnn_pkg.sv
// bnn_pkg: shared constants, FSM state type and width helper for the BNN FC layer.
package bnn_pkg;

  localparam int unsigned LANES_DEF  = 6;
  localparam int unsigned DIN_W_DEF  = 32;
  localparam int unsigned IN_LEN_DEF = 192;
  localparam int unsigned N_OUT_DEF  = 10;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FILL = 2'd1,
    CALC = 2'd2
  } bfc_state_t;

  // Accumulator width that cannot overflow for in_len signed din_w-bit terms.
  function automatic int unsigned acc_width(input int unsigned din_w, input int unsigned in_len);
    return din_w + $clog2(in_len) + 1;
  endfunction

endpackage

// File: rtl/bfc_lane_sum.sv
// bfc_lane_sum: signed +/- sum of LANES activations selected by 1-bit weights.
module bfc_lane_sum
  import bnn_pkg::*;
#(
  parameter int unsigned LANES = LANES_DEF,
  parameter int unsigned DIN_W = DIN_W_DEF,
  localparam int unsigned SUM_W = DIN_W + $clog2(LANES) + 1
) (
  input  logic [LANES*DIN_W-1:0] x,
  input  logic [LANES-1:0]       w,
  output logic signed [SUM_W-1:0] sum
);

  logic signed [SUM_W-1:0] term;

  // Weight 1 adds the lane, weight 0 subtracts it; one extra bit covers -(-2^(DIN_W-1)).
  always_comb begin
    sum  = '0;
    term = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      term = SUM_W'($signed(x[i*DIN_W +: DIN_W]));
      sum  = sum + (w[i] ? term : -term);
    end
  end

endmodule

// File: rtl/bfc_layer.sv
// bfc_layer: binary-weight fully-connected layer with serial weight load.
// Optional argmax classifier is built when BFC_ARGMAX_EN is defined.
module bfc_layer
  import bnn_pkg::*;
#(
  parameter int unsigned LANES  = LANES_DEF,
  parameter int unsigned DIN_W  = DIN_W_DEF,
  parameter int unsigned IN_LEN = IN_LEN_DEF,
  parameter int unsigned N_OUT  = N_OUT_DEF,
  localparam int unsigned BEATS = IN_LEN / LANES,
  localparam int unsigned ACC_W = acc_width(DIN_W, IN_LEN),
  localparam int unsigned IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_valid,
  input  logic                    w_bit,
  output logic                    w_ready,
  input  logic                    in_valid,
  input  logic [LANES*DIN_W-1:0]  in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic                    out_last,
  output logic signed [ACC_W-1:0] dout,
  output logic                    cls_valid,
  output logic [IDX_W-1:0]        cls_idx,
  output logic signed [ACC_W-1:0] cls_score
);

  localparam int unsigned SUM_W   = DIN_W + $clog2(LANES) + 1;
  localparam int unsigned NW      = N_OUT * IN_LEN;
  localparam int unsigned WADDR_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  bfc_state_t              state;
  logic [WADDR_W-1:0]      wptr;
  logic [WADDR_W-1:0]      rptr;
  logic [BEAT_W-1:0]       beat_cnt;
  logic [IDX_W-1:0]        n_cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [SUM_W-1:0] lane_sum;
  logic                    w_take;
  logic                    in_take;

  logic [NW-1:0]            wmem;
  logic [LANES*DIN_W-1:0]   fbuf [BEATS];

  // In FILL wptr sits at 0, so a reload bit always lands at index 0.
  assign w_take  = w_valid && ((state == LOAD) || ((state == FILL) && (beat_cnt == '0)));
  assign in_take = in_valid && (state == FILL) && !w_take;

  // Storage arrays carry no reset; the FSM forbids reading them before a full reload.
  always_ff @(posedge clk) begin
    if (w_take) wmem[wptr] <= w_bit;
    if (in_take) fbuf[beat_cnt] <= in_data;
  end

  bfc_lane_sum #(
    .LANES (LANES),
    .DIN_W (DIN_W)
  ) u_lane_sum (
    .x   (fbuf[beat_cnt]),
    .w   (wmem[rptr +: LANES]),
    .sum (lane_sum)
  );

  // Beat 0 of each neuron restarts the sum so neurons chain with no bubble.
  assign acc_next = ((beat_cnt == '0) ? '0 : acc) + ACC_W'(lane_sum);

  // Control FSM plus accumulator and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      wptr      <= '0;
      rptr      <= '0;
      beat_cnt  <= '0;
      n_cnt     <= '0;
      acc       <= '0;
      in_ready  <= 1'b0;
      w_ready   <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      dout      <= '0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      case (state)
        LOAD: begin
          if (w_valid) begin
            if (wptr == WADDR_W'(NW - 1)) begin
              state    <= FILL;
              wptr     <= '0;
              beat_cnt <= '0;
              in_ready <= 1'b1;
              w_ready  <= 1'b1;
            end else begin
              wptr <= wptr + WADDR_W'(1);
            end
          end
        end
        FILL: begin
          if (w_take) begin
            state    <= LOAD;
            wptr     <= WADDR_W'(1);
            in_ready <= 1'b0;
            w_ready  <= 1'b1;
          end else if (in_take) begin
            w_ready <= 1'b0;
            if (beat_cnt == BEAT_W'(BEATS - 1)) begin
              state    <= CALC;
              beat_cnt <= '0;
              n_cnt    <= '0;
              rptr     <= '0;
              in_ready <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        CALC: begin
          acc  <= acc_next;
          rptr <= rptr + WADDR_W'(LANES);
          if (beat_cnt == BEAT_W'(BEATS - 1)) begin
            beat_cnt  <= '0;
            dout      <= acc_next;
            out_valid <= 1'b1;
            out_last  <= (n_cnt == IDX_W'(N_OUT - 1));
            if (n_cnt == IDX_W'(N_OUT - 1)) begin
              state    <= FILL;
              n_cnt    <= '0;
              in_ready <= 1'b1;
              w_ready  <= 1'b1;
            end else begin
              n_cnt <= n_cnt + IDX_W'(1);
            end
          end else begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

`ifdef BFC_ARGMAX_EN
  logic [IDX_W-1:0]        cur_idx;
  logic [IDX_W-1:0]        best_idx;
  logic [IDX_W-1:0]        best_idx_next;
  logic signed [ACC_W-1:0] best;
  logic signed [ACC_W-1:0] best_next;
  logic                    take_max;

  // Strict greater-than keeps the lowest index on ties; neuron 0 seeds the max.
  always_comb begin
    take_max      = (cur_idx == '0) || (dout > best);
    best_next     = take_max ? dout : best;
    best_idx_next = take_max ? cur_idx : best_idx;
  end

  // Running max over each vector's douts, published one cycle after out_last.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_idx   <= '0;
      best_idx  <= '0;
      best      <= '0;
      cls_valid <= 1'b0;
      cls_idx   <= '0;
      cls_score <= '0;
    end else begin
      cls_valid <= 1'b0;
      if (out_valid) begin
        best     <= best_next;
        best_idx <= best_idx_next;
        cur_idx  <= out_last ? '0 : cur_idx + IDX_W'(1);
        if (out_last) begin
          cls_valid <= 1'b1;
          cls_idx   <= best_idx_next;
          cls_score <= best_next;
        end
      end
    end
  end
`else
  assign cls_valid = 1'b0;
  assign cls_idx   = '0;
  assign cls_score = '0;
`endif

endmodule

// File: tb/tb_bfc_layer.sv
// tb_bfc_layer: directed scoreboard bench for bfc_layer at default parameters.
module tb_bfc_layer;

  localparam int LANES  = 6;
  localparam int DIN_W  = 32;
  localparam int IN_LEN = 192;
  localparam int N_OUT  = 10;
  localparam int BEATS  = 32;
  localparam int ACC_W  = 41;
  localparam int IDX_W  = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   w_valid;
  logic                   w_bit;
  logic                   w_ready;
  logic                   in_valid;
  logic [LANES*DIN_W-1:0] din;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_last;
  logic [ACC_W-1:0]       dout;
  logic                   cls_valid;
  logic [IDX_W-1:0]       cls_idx;
  logic [ACC_W-1:0]       cls_score;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  bit          wt [N_OUT][IN_LEN];
  logic [31:0] act [IN_LEN];
  longint      exp_q [$];
  int          exp_cls_idx;
  longint      exp_cls_score;

  bfc_layer dut (
    .clk       (clk),
    .rst       (rst),
    .w_valid   (w_valid),
    .w_bit     (w_bit),
    .w_ready   (w_ready),
    .in_valid  (in_valid),
    .in_data   (din),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .dout      (dout),
    .cls_valid (cls_valid),
    .cls_idx   (cls_idx),
    .cls_score (cls_score)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    vectors++;
    assert (got === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_neuron(input int n, input bit v);
    for (int j = 0; j < IN_LEN; j++) wt[n][j] = v;
  endtask

  task automatic set_act(input logic [31:0] v);
    for (int j = 0; j < IN_LEN; j++) act[j] = v;
  endtask

  // Serial neuron-major load; optionally collides in_valid with the first bit.
  task automatic load_weights(input bit collide);
    for (int n = 0; n < N_OUT; n++) begin
      for (int j = 0; j < IN_LEN; j++) begin
        w_valid  = 1'b1;
        w_bit    = wt[n][j];
        in_valid = collide && (n == 0) && (j == 0);
        step();
        in_valid = 1'b0;
        if (collide && (n == 0) && (j == 0)) begin
          chk("collide_in_ready", 64'(in_ready), 64'd0);
          chk("collide_w_ready", 64'(w_ready), 64'd1);
        end
      end
    end
    w_valid = 1'b0;
    chk("fill_in_ready", 64'(in_ready), 64'd1);
    chk("fill_w_ready", 64'(w_ready), 64'd1);
  endtask

  // Reference dot products and argmax pushed to the scoreboard.
  task automatic expect_vector();
    longint s;
    longint best;
    int     bidx;
    best = 0;
    bidx = 0;
    for (int n = 0; n < N_OUT; n++) begin
      s = 0;
      for (int j = 0; j < IN_LEN; j++)
        s += wt[n][j] ? longint'($signed(act[j])) : -longint'($signed(act[j]));
      exp_q.push_back(s);
      if (n == 0 || s > best) begin
        best = s;
        bidx = n;
      end
    end
    exp_cls_idx   = bidx;
    exp_cls_score = best;
  endtask

  task automatic drive_vector(input bit gap, output int c);
    c = 0;
    for (int b = 0; b < BEATS; b++) begin
      for (int i = 0; i < LANES; i++) din[i*DIN_W +: DIN_W] = act[b*LANES + i];
      in_valid = 1'b1;
      c = cyc;
      step();
      in_valid = 1'b0;
      if (gap && b < BEATS - 1) begin
        if (b == 0) chk("w_ready_after_beat", 64'(w_ready), 64'd0);
        step();
      end
    end
  endtask

  task automatic collect(input int c);
    int k;
    logic [ACC_W-1:0] e;
    longint ev;
    k = 0;
    chk("in_ready_busy", 64'(in_ready), 64'd0);
    for (int budget = 0; budget < N_OUT*BEATS + 40 && k < N_OUT; budget++) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'(out_valid), 64'd0);
        end else begin
          ev = exp_q.pop_front();
          e  = ACC_W'(ev);
          chk("dout", 64'(dout), 64'(e));
          chk("out_cycle", 64'(cyc), 64'(c + 1 + (k + 1)*BEATS));
          chk("out_last", 64'(out_last), 64'(k == N_OUT - 1));
          chk("in_ready_at_out", 64'(in_ready), 64'(k == N_OUT - 1));
          k++;
        end
      end
      step();
    end
    chk("out_count", 64'(k), 64'(N_OUT));
`ifdef BFC_ARGMAX_EN
    e = ACC_W'(exp_cls_score);
    chk("cls_valid", 64'(cls_valid), 64'd1);
    chk("cls_idx", 64'(cls_idx), 64'(exp_cls_idx));
    chk("cls_score", 64'(cls_score), 64'(e));
`else
    chk("cls_valid_off", 64'(cls_valid), 64'd0);
    chk("cls_idx_off", 64'(cls_idx), 64'd0);
    chk("cls_score_off", 64'(cls_score), 64'd0);
`endif
    step();
    chk("cls_valid_pulse", 64'(cls_valid), 64'd0);
  endtask

  task automatic run_case(input bit gap);
    int c;
    expect_vector();
    drive_vector(gap, c);
    collect(c);
  endtask

  task automatic check_reset_values();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_w_ready", 64'(w_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_cls_valid", 64'(cls_valid), 64'd0);
    chk("rst_cls_idx", 64'(cls_idx), 64'd0);
    chk("rst_cls_score", 64'(cls_score), 64'd0);
  endtask

  initial begin
    int c;
    int seen_out;
    int seen_ready;

    rst      = 1'b1;
    w_valid  = 1'b0;
    w_bit    = 1'b0;
    in_valid = 1'b0;
    din      = '0;
    repeat (3) step();
    check_reset_values();
    rst = 1'b0;

    // All +1 weights, activations 1, back-to-back beats.
    for (int n = 0; n < N_OUT; n++) set_neuron(n, 1'b1);
    load_weights(1'b0);
    set_act(32'd1);
    run_case(1'b0);

    // Same data with a gap between every beat.
    run_case(1'b1);

    // Most negative activations: no wrap in the 41-bit accumulator.
    set_act(32'h8000_0000);
    run_case(1'b0);

    // Reload from FILL: even neurons -1, odd neurons +1, activations 3.
    for (int n = 0; n < N_OUT; n++) set_neuron(n, n[0]);
    load_weights(1'b0);
    set_act(32'd3);
    run_case(1'b0);

    // Random weights and activations; first weight collides with a beat.
    for (int n = 0; n < N_OUT; n++)
      for (int j = 0; j < IN_LEN; j++) wt[n][j] = 1'($urandom_range(0, 1));
    for (int j = 0; j < IN_LEN; j++) act[j] = $urandom;
    load_weights(1'b1);
    run_case(1'b0);

    // Single winning neuron 7, then a tie between neurons 2 and 7.
    for (int n = 0; n < N_OUT; n++) set_neuron(n, n == 7);
    load_weights(1'b0);
    set_act(32'd5);
    run_case(1'b0);
    set_neuron(2, 1'b1);
    load_weights(1'b0);
    run_case(1'b0);

    // Reset in the middle of CALC, then require a reload before any output.
    for (int n = 0; n < N_OUT; n++) set_neuron(n, 1'b1);
    load_weights(1'b0);
    set_act(32'd1);
    drive_vector(1'b0, c);
    repeat (99) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_values();
    seen_out   = 0;
    seen_ready = 0;
    for (int i = 0; i < 400; i++) begin
      in_valid = (i < BEATS);
      step();
      if (out_valid) seen_out++;
      if (in_ready) seen_ready++;
    end
    in_valid = 1'b0;
    chk("no_out_after_rst", 64'(seen_out), 64'd0);
    chk("no_in_ready_in_load", 64'(seen_ready), 64'd0);
    load_weights(1'b0);
    run_case(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
